// File: rtl/sc_statemachine_jug_if.sv
// Button/readback/command bundle between the player-position register datapath
// and its control FSM. The master side drives the buttons and readback.
interface sc_statemachine_jug_if #(
  parameter int DATAWIDTH     = 8,
  parameter int MOVECNT_WIDTH = 8
);
  logic                     btnLeft_InLow;
  logic                     btnRight_InLow;
  logic                     hit_InLow;
  logic [DATAWIDTH-1:0]     data_InBUS;
  logic                     clear_OutLow;
  logic                     load0_OutLow;
  logic                     load1_OutLow;
  logic [1:0]               shiftselection_Out;
  logic [MOVECNT_WIDTH-1:0] moveCount_OutBUS;
  logic                     busy_Out;

  modport master (
    output btnLeft_InLow, btnRight_InLow, hit_InLow, data_InBUS,
    input  clear_OutLow, load0_OutLow, load1_OutLow, shiftselection_Out,
           moveCount_OutBUS, busy_Out
  );

  modport slave (
    input  btnLeft_InLow, btnRight_InLow, hit_InLow, data_InBUS,
    output clear_OutLow, load0_OutLow, load1_OutLow, shiftselection_Out,
           moveCount_OutBUS, busy_Out
  );
endinterface

// File: rtl/sc_statemachine_jug.sv
// Control FSM for the player-position register: turns synchronized button presses
// into single rotate commands, blocks edge wraps, and sequences clear/load/respawn.
module sc_statemachine_jug #(
  parameter int DATAWIDTH      = 8,
  parameter int LOCKOUT_CYCLES = 4,
  parameter int LOCKOUT_WIDTH  = 8,
  parameter int MOVECNT_WIDTH  = 8
) (
  input logic                  SC_RegJUG_CLOCK_50,
  input logic                  SC_RegJUG_RESET_InHigh,
  sc_statemachine_jug_if.slave bus
);

  typedef enum logic [2:0] {
    INIT, LOAD0, IDLE, SHL, SHR, RESPAWN, LOCK
  } state_t;

  localparam logic [LOCKOUT_WIDTH-1:0] LOCK_LOAD = LOCKOUT_WIDTH'(LOCKOUT_CYCLES);
  localparam logic [LOCKOUT_WIDTH-1:0] LOCK_ONE  = LOCKOUT_WIDTH'(1);

  state_t                   r_state;
  logic                     r_l_s1, r_l_s2, r_l_d;
  logic                     r_r_s1, r_r_s2, r_r_d;
  logic [LOCKOUT_WIDTH-1:0] r_lock;
  logic [MOVECNT_WIDTH-1:0] r_mc;
  logic                     r_clear, r_load0, r_load1, r_busy;
  logic [1:0]               r_shift;

  logic                     w_l_evt, w_r_evt, w_l_go, w_r_go;
  logic [MOVECNT_WIDTH-1:0] w_mc_inc;

  // Two-flop synchronizers plus a delayed copy for falling-edge (press) detection.
  always_ff @(posedge SC_RegJUG_CLOCK_50 or posedge SC_RegJUG_RESET_InHigh) begin
    if (SC_RegJUG_RESET_InHigh) begin
      r_l_s1 <= 1'b1; r_l_s2 <= 1'b1; r_l_d <= 1'b1;
      r_r_s1 <= 1'b1; r_r_s2 <= 1'b1; r_r_d <= 1'b1;
    end else begin
      r_l_s1 <= bus.btnLeft_InLow;  r_l_s2 <= r_l_s1; r_l_d <= r_l_s2;
      r_r_s1 <= bus.btnRight_InLow; r_r_s2 <= r_r_s1; r_r_d <= r_r_s2;
    end
  end

  assign w_l_evt  = ~r_l_s2 & r_l_d;
  assign w_r_evt  = ~r_r_s2 & r_r_d;
  // A simultaneous left+right pair cancels; moves past either edge are refused.
  assign w_l_go   = w_l_evt & ~w_r_evt & ~bus.data_InBUS[DATAWIDTH-1];
  assign w_r_go   = w_r_evt & ~w_l_evt & ~bus.data_InBUS[0];
  assign w_mc_inc = (r_mc == '1) ? r_mc : r_mc + 1'b1;

  // Command outputs are registered together with the state they belong to, so a
  // shift command is on the wire during the SHL/SHR cycle itself.
  always_ff @(posedge SC_RegJUG_CLOCK_50 or posedge SC_RegJUG_RESET_InHigh) begin
    if (SC_RegJUG_RESET_InHigh) begin
      r_state <= INIT;
      r_lock  <= '0;
      r_mc    <= '0;
      r_clear <= 1'b1;
      r_load0 <= 1'b1;
      r_load1 <= 1'b1;
      r_shift <= 2'b00;
      r_busy  <= 1'b1;
    end else begin
      r_clear <= 1'b1;
      r_load0 <= 1'b1;
      r_load1 <= 1'b1;
      r_shift <= 2'b00;
      r_busy  <= 1'b1;
      case (r_state)
        INIT: begin
          r_clear <= 1'b0;
          r_state <= LOAD0;
        end
        LOAD0: begin
          r_load0 <= 1'b0;
          r_state <= IDLE;
        end
        IDLE: begin
          if (!bus.hit_InLow) begin
            r_load1 <= 1'b0;
            r_state <= RESPAWN;
          end else if (w_l_go) begin
            r_shift <= 2'b01;
            r_mc    <= w_mc_inc;
            r_state <= SHL;
          end else if (w_r_go) begin
            r_shift <= 2'b10;
            r_mc    <= w_mc_inc;
            r_state <= SHR;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        SHL, SHR, RESPAWN: begin
          r_lock  <= LOCK_LOAD;
          r_state <= LOCK;
        end
        LOCK: begin
          // Events arriving here are single-cycle pulses and simply expire.
          if (r_lock <= LOCK_ONE) begin
            r_lock  <= '0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_lock  <= r_lock - 1'b1;
          end
        end
        default: r_state <= INIT;
      endcase
    end
  end

  assign bus.clear_OutLow       = r_clear;
  assign bus.load0_OutLow       = r_load0;
  assign bus.load1_OutLow       = r_load1;
  assign bus.shiftselection_Out = r_shift;
  assign bus.moveCount_OutBUS   = r_mc;
  assign bus.busy_Out           = r_busy;

endmodule

// File: tb/tb_sc_statemachine_jug.sv
// Directed bench for sc_statemachine_jug: reset sequence, latency, edge blocking,
// lockout drop, respawn priority, counter saturation and mid-lockout reset.
module tb_sc_statemachine_jug;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0, n_fail = 0;
  int   n_shl = 0, n_shr = 0, n_ld1 = 0;
  int   exp_mc = 0;
  int   shl0, shr0, ld10;

  sc_statemachine_jug_if #(.DATAWIDTH(8), .MOVECNT_WIDTH(8)) bus ();

  sc_statemachine_jug #(
    .DATAWIDTH(8), .LOCKOUT_CYCLES(4), .LOCKOUT_WIDTH(8), .MOVECNT_WIDTH(8)
  ) dut (
    .SC_RegJUG_CLOCK_50    (clk),
    .SC_RegJUG_RESET_InHigh(rst),
    .bus                   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance n edges, sampling 1 time unit after each and tallying commands.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (bus.shiftselection_Out == 2'b01) n_shl++;
      if (bus.shiftselection_Out == 2'b10) n_shr++;
      if (bus.load1_OutLow == 1'b0)        n_ld1++;
    end
  endtask

  task automatic mark;
    shl0 = n_shl; shr0 = n_shr; ld10 = n_ld1;
  endtask

  task automatic press(input logic l, input logic r);
    bus.btnLeft_InLow  = ~l;
    bus.btnRight_InLow = ~r;
    run(4);
    bus.btnLeft_InLow  = 1'b1;
    bus.btnRight_InLow = 1'b1;
    run(8);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_clear"}, bus.clear_OutLow, 1'b1);
    chk({tag, "_load0"}, bus.load0_OutLow, 1'b1);
    chk({tag, "_load1"}, bus.load1_OutLow, 1'b1);
    chk({tag, "_shift"}, bus.shiftselection_Out, 2'b00);
    chk({tag, "_mc"},    bus.moveCount_OutBUS, 8'd0);
    chk({tag, "_busy"},  bus.busy_Out, 1'b1);
  endtask

  // Called one time unit after an edge with reset still high.
  task automatic release_and_check_init(input string tag);
    rst = 1'b0;
    run(1);
    chk({tag, "_c1_clear"}, bus.clear_OutLow, 1'b0);
    chk({tag, "_c1_load0"}, bus.load0_OutLow, 1'b1);
    chk({tag, "_c1_busy"},  bus.busy_Out, 1'b1);
    run(1);
    chk({tag, "_c2_clear"}, bus.clear_OutLow, 1'b1);
    chk({tag, "_c2_load0"}, bus.load0_OutLow, 1'b0);
    chk({tag, "_c2_busy"},  bus.busy_Out, 1'b1);
    run(1);
    chk({tag, "_c3_load0"}, bus.load0_OutLow, 1'b1);
    chk({tag, "_c3_busy"},  bus.busy_Out, 1'b0);
  endtask

  initial begin
    bus.btnLeft_InLow  = 1'b1;
    bus.btnRight_InLow = 1'b1;
    bus.hit_InLow      = 1'b1;
    bus.data_InBUS     = 8'b0000_1000;

    // 1. reset values and INIT/LOAD0 sequence
    run(3);
    chk_reset_vals("rst");
    release_and_check_init("init");
    run(2);

    // 2. left press latency, single shift, lockout length, held button
    mark();
    bus.btnLeft_InLow = 1'b0;           // sampled at next edge (k)
    run(1); chk("lat_k0",  bus.shiftselection_Out, 2'b00);
    run(1); chk("lat_k1",  bus.shiftselection_Out, 2'b00);
    run(1); chk("lat_k2",  bus.shiftselection_Out, 2'b01);
    exp_mc = 1;
    chk("lat_mc", bus.moveCount_OutBUS, exp_mc);
    chk("lat_busy", bus.busy_Out, 1'b1);
    run(1); chk("lat_k3",  bus.shiftselection_Out, 2'b00);
    run(3); chk("lock_busy", bus.busy_Out, 1'b1);
    run(1); chk("lock_exit", bus.busy_Out, 1'b0);
    run(50);
    chk("hold_shl", n_shl - shl0, 1);
    chk("hold_mc",  bus.moveCount_OutBUS, exp_mc);
    bus.btnLeft_InLow = 1'b1;
    run(5);

    // 3. edge blocking
    mark();
    bus.data_InBUS = 8'b1000_0000;
    press(1'b1, 1'b0);
    chk("blk_msb_shl", n_shl - shl0, 0);
    chk("blk_msb_mc",  bus.moveCount_OutBUS, exp_mc);
    bus.data_InBUS = 8'b0000_0001;
    press(1'b0, 1'b1);
    chk("blk_lsb_shr", n_shr - shr0, 0);
    chk("blk_lsb_busy", bus.busy_Out, 1'b0);
    press(1'b1, 1'b0);
    exp_mc++;
    chk("lsb_left_shl", n_shl - shl0, 1);
    chk("lsb_left_mc",  bus.moveCount_OutBUS, exp_mc);

    // 4. simultaneous presses cancel; a press during LOCK is dropped
    bus.data_InBUS = 8'b0000_1000;
    mark();
    press(1'b1, 1'b1);
    chk("both_shl", n_shl - shl0, 0);
    chk("both_shr", n_shr - shr0, 0);
    chk("both_mc",  bus.moveCount_OutBUS, exp_mc);
    mark();
    bus.btnLeft_InLow = 1'b0;
    run(3);
    chk("lockdrop_shift", bus.shiftselection_Out, 2'b01);
    exp_mc++;
    bus.btnRight_InLow = 1'b0;
    run(2);
    bus.btnLeft_InLow  = 1'b1;
    bus.btnRight_InLow = 1'b1;
    run(15);
    chk("lockdrop_shl", n_shl - shl0, 1);
    chk("lockdrop_shr", n_shr - shr0, 0);
    chk("lockdrop_mc",  bus.moveCount_OutBUS, exp_mc);

    // 5. hit wins over a coincident left event
    mark();
    bus.btnLeft_InLow = 1'b0;
    run(2);                             // left event visible now
    bus.hit_InLow = 1'b0;
    run(1);
    chk("hit_load1", bus.load1_OutLow, 1'b0);
    chk("hit_shift", bus.shiftselection_Out, 2'b00);
    chk("hit_busy",  bus.busy_Out, 1'b1);
    bus.hit_InLow     = 1'b1;
    bus.btnLeft_InLow = 1'b1;
    run(1);
    chk("hit_load1_off", bus.load1_OutLow, 1'b1);
    chk("hit_lock_busy", bus.busy_Out, 1'b1);
    run(10);
    chk("hit_ld1_cnt", n_ld1 - ld10, 1);
    chk("hit_shl_cnt", n_shl - shl0, 0);
    chk("hit_mc",      bus.moveCount_OutBUS, exp_mc);

    // 6. saturation, then reset during LOCK
    for (int i = 0; i < 260; i++) begin
      press(1'b1, 1'b0);
      if (exp_mc < 255) exp_mc++;
      if (i == 100) chk("sat_mid", bus.moveCount_OutBUS, exp_mc);
    end
    chk("sat_mc", bus.moveCount_OutBUS, 8'd255);
    bus.btnLeft_InLow = 1'b0;
    run(3);
    chk("sat_shift", bus.shiftselection_Out, 2'b01);
    chk("sat_hold",  bus.moveCount_OutBUS, 8'd255);
    run(2);                             // now in LOCK
    bus.btnLeft_InLow = 1'b1;
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    run(2);
    chk_reset_vals("midrst_hold");
    release_and_check_init("reinit");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
